// File: rtl/dmem_resp_pkg.sv
// Types, state constants and byte-lane helpers shared by the dmem_resp slice.
`include "define.v"

package dmem_resp_pkg;

  localparam int ADDR_W = `DataCatchDepth;
  localparam int WORD_W = ADDR_W - 2;

  localparam logic [1:0] ST_IDLE = `DMEM_ST_IDLE;
  localparam logic [1:0] ST_WAIT = `DMEM_ST_WAIT;
  localparam logic [1:0] ST_RESP = `DMEM_ST_RESP;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [3:0]        rden;
    logic [3:0]        wren;
    logic [31:0]       wdata;
  } req_t;

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] lanes);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // Legal masks are single bytes, aligned halves and the full word; the
  // address low bits must name the lowest enabled lane.
  function automatic logic lane_ok(input logic [3:0] mask, input logic [1:0] lsb);
    logic ok;
    case (mask)
      4'b0001: ok = (lsb == 2'd0);
      4'b0010: ok = (lsb == 2'd1);
      4'b0100: ok = (lsb == 2'd2);
      4'b1000: ok = (lsb == 2'd3);
      4'b0011: ok = (lsb == 2'd0);
      4'b1100: ok = (lsb == 2'd2);
      4'b1111: ok = (lsb == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bus between a memory client (master) and dmem_resp (slave).
`include "define.v"

interface dmem_if #(parameter int AW = `DataCatchDepth);
  logic [AW-1:0] MEMaddr;
  logic [3:0]    MEMrden;
  logic [3:0]    MEMwren;
  logic [31:0]   MEMwrdata;
  logic [31:0]   MEMrddata;
  logic          MEMrd_vld;
  logic          MEMwr_done;
  logic          busy;
  logic          error;

  modport master (
    output MEMaddr, MEMrden, MEMwren, MEMwrdata,
    input  MEMrddata, MEMrd_vld, MEMwr_done, busy, error
  );

  modport slave (
    input  MEMaddr, MEMrden, MEMwren, MEMwrdata,
    output MEMrddata, MEMrd_vld, MEMwr_done, busy, error
  );
endinterface

// File: rtl/define.v
// Shared build constants for the dmem_resp slice: address width, FSM state
// encodings and the default response wait.
`ifndef DMEM_DEFINE_V
`define DMEM_DEFINE_V

`define DataCatchDepth     8
`define DMEM_ST_IDLE       2'd0
`define DMEM_ST_WAIT       2'd1
`define DMEM_ST_RESP       2'd2
`define DMEM_WAIT_CYC_DEF  1

`endif

// File: rtl/dmem_resp_ram.sv
// Word-organised RAM with per-byte-lane write enables and a registered read port.
module dmem_ram #(
  parameter int WORD_W = 6
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [WORD_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**WORD_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder with programmable response latency.
// Optional build macro DMEM_MISALIGN_CHK_EN rejects illegal/misaligned lane masks.
//
// state | meaning
// IDLE  | ready; accepts a read or write request
// WAIT  | counting WAIT_CYC latency cycles
// RESP  | commit write / return read data, then back to IDLE
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned WAIT_CYC = `DMEM_WAIT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  req_t              req;
  logic              req_any;
  logic              req_both;
  logic              req_bad;
  logic              accept;
  logic [WORD_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_q;

  assign req_any  = (|bus.MEMrden) || (|bus.MEMwren);
  assign req_both = (|bus.MEMrden) && (|bus.MEMwren);

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_bad = req_any && !req_both &&
                   !lane_ok(bus.MEMrden | bus.MEMwren, bus.MEMaddr[1:0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.MEMaddr[1:0];
  assign req_bad = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && req_any && !req_both && !req_bad;

  // Address goes straight to the RAM while idle so read data is ready even
  // when WAIT_CYC is zero and RESP follows the accept edge directly.
  assign ram_addr = (state == ST_IDLE) ? bus.MEMaddr[ADDR_W-1:2] : req.word;
  assign ram_we   = (state == ST_RESP && !rst) ? req.wren : 4'b0000;

  dmem_ram #(.WORD_W(WORD_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req.wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= 4'd0;
      req            <= '0;
      bus.MEMrddata  <= 32'h0;
      bus.MEMrd_vld  <= 1'b0;
      bus.MEMwr_done <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.MEMrd_vld  <= 1'b0;
      bus.MEMwr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_both || req_bad) bus.error <= 1'b1;
          if (accept) begin
            req.word  <= bus.MEMaddr[ADDR_W-1:2];
            req.rden  <= bus.MEMrden;
            req.wren  <= bus.MEMwren;
            req.wdata <= bus.MEMwrdata;
            if (WAIT_CYC > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (|req.rden) begin
            bus.MEMrd_vld <= 1'b1;
            bus.MEMrddata <= lane_mask(ram_q, req.rden);
          end
          if (|req.wren) bus.MEMwr_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp with WAIT_CYC = 1.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  dmem_if bus();

  dmem_resp #(.WAIT_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [ADDR_W-1:0] a, input logic [3:0] rd,
                       input logic [3:0] wr, input logic [31:0] d);
    bus.MEMaddr   = a;
    bus.MEMrden   = rd;
    bus.MEMwren   = wr;
    bus.MEMwrdata = d;
  endtask

  task automatic idle_bus();
    drive('0, 4'b0, 4'b0, 32'h0);
  endtask

  // Issue one request and capture outputs on the negedges following the
  // accept edge N, edge N+1 and edge N+2 (the expected pulse cycle).
  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [3:0] rd,
                        input logic [3:0] wr, input logic [31:0] d,
                        output logic busy_n, output logic [1:0] p1,
                        output logic [1:0] p2, output logic [31:0] data2,
                        output logic busy2);
    @(negedge clk); drive(a, rd, wr, d);
    @(negedge clk); idle_bus(); busy_n = bus.busy;
    @(negedge clk); p1 = {bus.MEMrd_vld, bus.MEMwr_done};
    @(negedge clk); p2 = {bus.MEMrd_vld, bus.MEMwr_done};
    data2 = bus.MEMrddata; busy2 = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    tot_cnt++; if (bus.MEMrddata !== 32'h0) $display("FAIL rst_rddata: got %h want 0", bus.MEMrddata); else pass_cnt++;
    tot_cnt++; if ({bus.MEMrd_vld, bus.MEMwr_done} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {bus.MEMrd_vld, bus.MEMwr_done}); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    tot_cnt++; if (bus.error !== 1'b0) $display("FAIL rst_error: got %b want 0", bus.error); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    do_req(8'h10, 4'b0000, 4'b1111, 32'hDEADBEEF, bn, p1, p2, d2, b2);
    tot_cnt++; if (bn !== 1'b1) $display("FAIL wr_busy: got %b want 1", bn); else pass_cnt++;
    tot_cnt++; if (p1 !== 2'b00) $display("FAIL wr_early_pulse: got %b want 00", p1); else pass_cnt++;
    tot_cnt++; if (p2 !== 2'b01) $display("FAIL wr_done_pulse: got %b want 01", p2); else pass_cnt++;
    tot_cnt++; if (b2 !== 1'b0) $display("FAIL wr_busy_end: got %b want 0", b2); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (bus.MEMwr_done !== 1'b0) $display("FAIL wr_pulse_width: got %b want 0", bus.MEMwr_done); else pass_cnt++;
    do_req(8'h10, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (p2 !== 2'b10) $display("FAIL rd_vld_pulse: got %b want 10", p2); else pass_cnt++;
    tot_cnt++; if (d2 !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", d2); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if ({bus.MEMrd_vld, bus.MEMrddata} !== {1'b0, 32'hDEADBEEF}) $display("FAIL rd_hold: got %b %h want 0 deadbeef", bus.MEMrd_vld, bus.MEMrddata); else pass_cnt++;
  endtask

  task automatic test_read_mask();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    do_req(8'h10, 4'b0011, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if ({p2, d2} !== {2'b10, 32'h0000BEEF}) $display("FAIL rd_mask_0011: got %b %h want 10 0000beef", p2, d2); else pass_cnt++;
    do_req(8'h13, 4'b1000, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if ({p2, d2} !== {2'b10, 32'hDE000000}) $display("FAIL rd_mask_1000: got %b %h want 10 de000000", p2, d2); else pass_cnt++;
    do_req(8'h14, 4'b0000, 4'b1111, 32'hCAFEF00D, bn, p1, p2, d2, b2);
    do_req(8'h14, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'hCAFEF00D) $display("FAIL rd_word_14: got %h want cafef00d", d2); else pass_cnt++;
    do_req(8'h10, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'hDEADBEEF) $display("FAIL rd_word_10: got %h want deadbeef", d2); else pass_cnt++;
  endtask

  task automatic test_byte_write();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    do_req(8'h10, 4'b0000, 4'b1111, 32'h11223344, bn, p1, p2, d2, b2);
    do_req(8'h12, 4'b0000, 4'b0100, 32'hAAAAAAAA, bn, p1, p2, d2, b2);
    tot_cnt++; if (p2 !== 2'b01) $display("FAIL byte_wr_done: got %b want 01", p2); else pass_cnt++;
    do_req(8'h10, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'h11AA3344) $display("FAIL byte_wr_merge: got %h want 11aa3344", d2); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    int extra;
    @(negedge clk); drive(8'h18, 4'b0000, 4'b1111, 32'h12345678);
    @(negedge clk); drive(8'h18, 4'b0000, 4'b1111, 32'hFFFFFFFF);
    tot_cnt++; if (bus.busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", bus.busy); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (bus.MEMwr_done !== 1'b0) $display("FAIL ign_early: got %b want 0", bus.MEMwr_done); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (bus.MEMwr_done !== 1'b1) $display("FAIL ign_first_done: got %b want 1", bus.MEMwr_done); else pass_cnt++;
    idle_bus();
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.MEMwr_done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    tot_cnt++; if (extra !== 0) $display("FAIL ign_second_pulse: got %0d want 0", extra); else pass_cnt++;
    do_req(8'h18, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'h12345678) $display("FAIL ign_data: got %h want 12345678", d2); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    @(negedge clk); drive(8'h10, 4'b1111, 4'b0000, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); seen[i] = bus.MEMrd_vld;
    end
    idle_bus();
    tot_cnt++; if (seen !== 6'b100100) $display("FAIL b2b_pattern: got %b want 100100", seen); else pass_cnt++;
    tot_cnt++; if (bus.MEMrddata !== 32'h11AA3344) $display("FAIL b2b_data: got %h want 11aa3344", bus.MEMrddata); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    int pulses;
    @(negedge clk); drive(8'h10, 4'b0000, 4'b1111, 32'hBADC0DE5);
    @(negedge clk); idle_bus(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.MEMwr_done === 1'b1) pulses++;
    end
    tot_cnt++; if (pulses !== 0) $display("FAIL abort_pulse: got %0d want 0", pulses); else pass_cnt++;
    do_req(8'h10, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'h11AA3344) $display("FAIL abort_old_data: got %h want 11aa3344", d2); else pass_cnt++;
  endtask

  task automatic test_error();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    @(negedge clk); drive(8'h10, 4'b1111, 4'b0001, 32'h000000FF);
    @(negedge clk); idle_bus();
    tot_cnt++; if ({bus.error, bus.busy} !== 2'b10) $display("FAIL both_err_busy: got %b want 10", {bus.error, bus.busy}); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if ({bus.MEMrd_vld, bus.MEMwr_done, bus.busy} !== 3'b000) $display("FAIL both_no_pulse: got %b want 000", {bus.MEMrd_vld, bus.MEMwr_done, bus.busy}); else pass_cnt++;
    do_req(8'h10, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
    tot_cnt++; if (d2 !== 32'h11AA3344) $display("FAIL both_no_write: got %h want 11aa3344", d2); else pass_cnt++;
    tot_cnt++; if (bus.error !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.error); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tot_cnt++; if (bus.error !== 1'b0) $display("FAIL err_clear: got %b want 0", bus.error); else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic bn, b2; logic [1:0] p1, p2; logic [31:0] d2;
    do_req(8'h12, 4'b1111, 4'b0000, 32'h0, bn, p1, p2, d2, b2);
`ifdef DMEM_MISALIGN_CHK_EN
    tot_cnt++; if ({bn, p1, p2} !== 5'b00000) $display("FAIL misalign_drop: got %b want 00000", {bn, p1, p2}); else pass_cnt++;
    tot_cnt++; if (bus.error !== 1'b1) $display("FAIL misalign_err: got %b want 1", bus.error); else pass_cnt++;
`else
    tot_cnt++; if ({p2, d2} !== {2'b10, 32'h11AA3344}) $display("FAIL misalign_word: got %b %h want 10 11aa3344", p2, d2); else pass_cnt++;
    tot_cnt++; if (bus.error !== 1'b0) $display("FAIL misalign_err: got %b want 0", bus.error); else pass_cnt++;
`endif
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_write_read();
    test_read_mask();
    test_byte_write();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_error();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter: WAIT_CYC, default 1, extra wait cycles between request accept and response (0..15).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: MEMaddr  input  `DataCatchDepth  byte address of the request.
REQ-005 Port: MEMrden  input  4  per-byte-lane read enable; nonzero = read request.
REQ-006 Port: MEMwren  input  4  per-byte-lane write enable; nonzero = write request.
REQ-007 Port: MEMwrdata  input  32  write data, lane i = bits 8i+7:8i.
REQ-008 Port: MEMrddata  output  32  read data, held until next read response.
REQ-009 Port: MEMrd_vld  output  1  one-cycle pulse, MEMrddata valid.
REQ-010 Port: MEMwr_done  output  1  one-cycle pulse, write committed.
REQ-011 Port: busy  output  1  high while a request is in flight; new requests ignored.
REQ-012 Port: error  output  1  sticky illegal-request flag, cleared only by rst.

Function
REQ-013 Storage SHALL be 2^(`DataCatchDepth-2) 32-bit words, indexed by MEMaddr[`DataCatchDepth-1:2].
REQ-014 FSM states SHALL be IDLE, WAIT, RESP.
REQ-015 In IDLE, request accepted on an edge where |MEMrden or |MEMwren; address, masks, and data latched; busy goes high the following cycle.
REQ-016 IDLE->WAIT on accept if WAIT_CYC>0, else IDLE->RESP; WAIT counts WAIT_CYC cycles then ->RESP; RESP->IDLE unconditionally.
REQ-017 Latency: request accepted at edge N produces MEMrd_vld/MEMwr_done high during the cycle after edge N+1+WAIT_CYC.
REQ-018 Read: lanes with MEMrden bit set return stored bytes; disabled lanes return 0x00.
REQ-019 Write: only lanes with MEMwren bit set updated; commit on RESP edge, visible to any later read.
REQ-020 Both MEMrden and MEMwren nonzero on the same edge: no access, no pulse, state stays IDLE, error set.
REQ-021 busy SHALL be low only in IDLE; inputs while busy SHALL have no effect.
REQ-022 Back-to-back: a request present on the edge RESP->IDLE is not accepted; the earliest accept is the next edge.

Reset
REQ-023 rst SHALL force IDLE; MEMrddata=0, MEMrd_vld=0, MEMwr_done=0, busy=0, error=0, wait counter=0.
REQ-024 Storage contents SHALL NOT be reset.
REQ-025 rst mid-operation SHALL abort: a pending write is not committed, no pulse issued.

Configuration
REQ-026 Macro DMEM_MISALIGN_CHK_EN defined: a mask outside {0001,0010,0100,1000,0011,1100,1111}, or MEMaddr[1:0] not equal to the mask's lowest set lane index, sets error and the request is dropped (stays IDLE).
REQ-027 Macro undefined: no alignment check; MEMaddr[1:0] ignored, mask applied as given.

Structure
REQ-028 `DataCatchDepth, the FSM state encodings, and the WAIT_CYC default SHALL live in define.v.
REQ-029 Byte-lane synchronous RAM SHALL be a sub-module dmem_ram (per-lane write enable, registered read).

Verification
REQ-030 WAIT_CYC=1: write 0xDEADBEEF, mask 1111, addr 0x10; then read 1111 at 0x10 -> MEMwr_done 3 cycles after accept, MEMrddata=0xDEADBEEF with MEMrd_vld.
REQ-031 Byte write 0xAA mask 0100 at 0x12 over 0x11223344, read 1111 -> 0x11AA3344.
REQ-032 Read mask 0011 at 0x10 of 0xDEADBEEF -> MEMrddata=0x0000BEEF.
REQ-033 Request while busy -> ignored, no second pulse; rst during WAIT of a write -> old data read back.
REQ-034 MEMrden=1111 and MEMwren=0001 together -> error=1, no pulse, busy stays 0.
REQ-035 With DMEM_MISALIGN_CHK_EN: read 1111 at 0x12 -> error=1, no MEMrd_vld; without it -> word at 0x10 returned.
